// File: rtl/regmap_access_arbiter.sv
// ---------------------------------------------------------------------------
// regmap_access_arbiter
//
// Purpose:
//   Shares the single-port register map between the I2C slave and the
//   SPI 3-wire slave. Each slave posts a one-cycle request pulse. The arbiter
//   holds one pending command per port and serves the ports round-robin. Each
//   served command produces one regmap strobe, then a read-data update and an
//   ack pulse back to the owning slave.
//
// Handshake:
//   A request is a single-cycle pulse on *_req. Command fields (*_wr, *_addr,
//   *_wdata) are sampled only on the edge where *_req=1. A request is accepted
//   when the port has nothing pending, or when its pending command is being
//   acked in that same cycle. A request that arrives while the port is still
//   pending is dropped, and the port's sticky overrun bit is set. *_ack is a
//   one-cycle pulse. *_rdata is valid from the ack cycle onward and holds
//   until the next read completes for that port.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i2c_req/wr/addr/wdata           I2C command input
//   i2c_ack, i2c_rdata              I2C completion / read data
//   spi_req/wr/addr/wdata           SPI command input
//   spi_ack, spi_rdata              SPI completion / read data
//   rm_en/wr/addr/wdata, rm_rdata   regmap access port (read data one cycle
//                                   after rm_en)
//   owner_spi                       1 while SPI owns the current access
//   overrun[1:0]                    sticky overrun flags (bit0 I2C, bit1 SPI)
//   contention_cnt                  saturating count of grants made while
//                                   both ports were pending (only with
//                                   REGMAP_ARB_STATS_EN defined)
//   dbg_state                       current FSM state (IDLE=0, ACCESS=1,
//                                   RESP=2)
//
// Optional feature macro: REGMAP_ARB_STATS_EN
// ---------------------------------------------------------------------------
module regmap_access_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2c_req,
  input  logic              i2c_wr,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic              i2c_ack,
  output logic [DATA_W-1:0] i2c_rdata,
  input  logic              spi_req,
  input  logic              spi_wr,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_ack,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              rm_en,
  output logic              rm_wr,
  output logic [ADDR_W-1:0] rm_addr,
  output logic [DATA_W-1:0] rm_wdata,
  input  logic [DATA_W-1:0] rm_rdata,
  output logic              owner_spi,
  output logic [1:0]        overrun,
`ifdef REGMAP_ARB_STATS_EN
  output logic [CNT_W-1:0]  contention_cnt,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_i2c_pend;
  logic                r_i2c_wr;
  logic [ADDR_W-1:0]   r_i2c_addr;
  logic [DATA_W-1:0]   r_i2c_wdata;
  logic                r_spi_pend;
  logic                r_spi_wr;
  logic [ADDR_W-1:0]   r_spi_addr;
  logic [DATA_W-1:0]   r_spi_wdata;

  logic                r_last_spi;
  logic                r_owner_spi;
  logic                r_rm_wr;
  logic [ADDR_W-1:0]   r_rm_addr;
  logic [DATA_W-1:0]   r_rm_wdata;
  logic [DATA_W-1:0]   r_i2c_rdata;
  logic [DATA_W-1:0]   r_spi_rdata;
  logic [1:0]          r_overrun;

  logic                w_grant;
  logic                w_grant_spi;
  logic                w_both_pend;
  logic                w_done_i2c;
  logic                w_done_spi;
  logic                w_i2c_accept;
  logic                w_spi_accept;
  logic                w_i2c_ovr;
  logic                w_spi_ovr;
  logic                w_i2c_live;
  logic                w_spi_live;

  // Arbitration: a lone pending port wins; on a tie the port that was not
  // granted last wins.
  assign w_both_pend = r_i2c_pend & r_spi_pend;
  assign w_grant     = (r_state == ST_IDLE) & (r_i2c_pend | r_spi_pend);
  assign w_grant_spi = r_spi_pend & (~r_i2c_pend | ~r_last_spi);

  // RESP is the ack cycle of the owner; its pending flag clears on that edge.
  assign w_done_i2c = (r_state == ST_RESP) & ~r_owner_spi;
  assign w_done_spi = (r_state == ST_RESP) &  r_owner_spi;

  // A request landing on the ack edge is accepted because the slot frees on
  // that same edge.
  assign w_i2c_accept = i2c_req & (~r_i2c_pend | w_done_i2c);
  assign w_spi_accept = spi_req & (~r_spi_pend | w_done_spi);
  assign w_i2c_ovr    = i2c_req &  r_i2c_pend & ~w_done_i2c;
  assign w_spi_ovr    = spi_req &  r_spi_pend & ~w_done_spi;

  // During the ack cycle the regmap read data is passed straight through so
  // rdata is valid together with ack; it is registered on the same edge.
  assign w_i2c_live = w_done_i2c & ~r_rm_wr;
  assign w_spi_live = w_done_spi & ~r_rm_wr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-port pending slot and command latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i2c_pend  <= 1'b0;
      r_i2c_wr    <= 1'b0;
      r_i2c_addr  <= '0;
      r_i2c_wdata <= '0;
      r_spi_pend  <= 1'b0;
      r_spi_wr    <= 1'b0;
      r_spi_addr  <= '0;
      r_spi_wdata <= '0;
      r_overrun   <= 2'b00;
    end else begin
      r_i2c_pend <= w_i2c_accept | (r_i2c_pend & ~w_done_i2c);
      r_spi_pend <= w_spi_accept | (r_spi_pend & ~w_done_spi);
      if (w_i2c_accept) begin
        r_i2c_wr    <= i2c_wr;
        r_i2c_addr  <= i2c_addr;
        r_i2c_wdata <= i2c_wdata;
      end
      if (w_spi_accept) begin
        r_spi_wr    <= spi_wr;
        r_spi_addr  <= spi_addr;
        r_spi_wdata <= spi_wdata;
      end
      if (w_i2c_ovr) r_overrun[0] <= 1'b1;
      if (w_spi_ovr) r_overrun[1] <= 1'b1;
    end
  end

  // Grant: load the regmap command from the winner's latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_spi  <= 1'b1;
      r_owner_spi <= 1'b0;
      r_rm_wr     <= 1'b0;
      r_rm_addr   <= '0;
      r_rm_wdata  <= '0;
    end else if (w_grant) begin
      r_last_spi  <= w_grant_spi;
      r_owner_spi <= w_grant_spi;
      r_rm_wr     <= w_grant_spi ? r_spi_wr    : r_i2c_wr;
      r_rm_addr   <= w_grant_spi ? r_spi_addr  : r_i2c_addr;
      r_rm_wdata  <= w_grant_spi ? r_spi_wdata : r_i2c_wdata;
    end
  end

  // Read data capture; writes leave the owner's rdata untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i2c_rdata <= '0;
      r_spi_rdata <= '0;
    end else begin
      if (w_i2c_live) r_i2c_rdata <= rm_rdata;
      if (w_spi_live) r_spi_rdata <= rm_rdata;
    end
  end

`ifdef REGMAP_ARB_STATS_EN
  logic [CNT_W-1:0] r_contention_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_contention_cnt <= '0;
    end else if (w_grant && w_both_pend && (r_contention_cnt != {CNT_W{1'b1}})) begin
      r_contention_cnt <= r_contention_cnt + 1'b1;
    end
  end

  assign contention_cnt = r_contention_cnt;
`endif

  assign rm_en     = (r_state == ST_ACCESS);
  assign rm_wr     = r_rm_wr;
  assign rm_addr   = r_rm_addr;
  assign rm_wdata  = r_rm_wdata;
  assign i2c_ack   = w_done_i2c;
  assign spi_ack   = w_done_spi;
  assign i2c_rdata = w_i2c_live ? rm_rdata : r_i2c_rdata;
  assign spi_rdata = w_spi_live ? rm_rdata : r_spi_rdata;
  assign owner_spi = r_owner_spi;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_regmap_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regmap_access_arbiter
//
// Bench for regmap_access_arbiter: a behavioural single-port regmap with a
// registered read, a vector table of uncontended accesses, and hand-written
// sequences for ties, back-to-back saturation, overrun and reset mid-access.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, which keeps sampling away from the active edge.
// ---------------------------------------------------------------------------
module tb_regmap_access_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              i2c_req = 1'b0, i2c_wr = 1'b0;
  logic [ADDR_W-1:0] i2c_addr = '0;
  logic [DATA_W-1:0] i2c_wdata = '0;
  logic              i2c_ack;
  logic [DATA_W-1:0] i2c_rdata;
  logic              spi_req = 1'b0, spi_wr = 1'b0;
  logic [ADDR_W-1:0] spi_addr = '0;
  logic [DATA_W-1:0] spi_wdata = '0;
  logic              spi_ack;
  logic [DATA_W-1:0] spi_rdata;
  logic              rm_en, rm_wr;
  logic [ADDR_W-1:0] rm_addr;
  logic [DATA_W-1:0] rm_wdata;
  logic [DATA_W-1:0] rm_rdata;
  logic              owner_spi;
  logic [1:0]        overrun;
  logic [1:0]        dbg_state;
`ifdef REGMAP_ARB_STATS_EN
  logic [CNT_W-1:0]  contention_cnt;
`endif

  regmap_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i2c_req(i2c_req), .i2c_wr(i2c_wr), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_ack(i2c_ack), .i2c_rdata(i2c_rdata),
    .spi_req(spi_req), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_ack(spi_ack), .spi_rdata(spi_rdata),
    .rm_en(rm_en), .rm_wr(rm_wr), .rm_addr(rm_addr), .rm_wdata(rm_wdata),
    .rm_rdata(rm_rdata), .owner_spi(owner_spi), .overrun(overrun),
`ifdef REGMAP_ARB_STATS_EN
    .contention_cnt(contention_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- regmap model ----------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
      mem[1]   <= 8'h24;
      rm_rdata <= '0;
    end else if (rm_en) begin
      if (rm_wr) mem[rm_addr] <= rm_wdata;
      else       rm_rdata     <= mem[rm_addr];
    end
  end

  // Grant log {owner_spi, rm_wr, rm_addr, rm_wdata}, appended on each strobe.
  logic [16:0] act_q[$];
  always @(negedge clk) begin
    if (rst_n && rm_en) act_q.push_back({owner_spi, rm_wr, rm_addr, rm_wdata});
  end

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    i2c_req = 1'b0;
    spi_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic post_i2c(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    i2c_req = 1'b1; i2c_wr = wr; i2c_addr = a; i2c_wdata = d;
  endtask

  task automatic post_spi(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    spi_req = 1'b1; spi_wr = wr; spi_addr = a; spi_wdata = d;
  endtask

  task automatic run_cycles(input int n, output int n_i2c, output int n_spi);
    n_i2c = 0;
    n_spi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i2c_ack) n_i2c++;
      if (spi_ack) n_spi++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              is_spi;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];
  logic [DATA_W-1:0] exp_i2c_rd;
  logic [DATA_W-1:0] exp_spi_rd;
  int base;
  int n_i2c, n_spi;
  int i2c_sent, spi_sent, i2c_acks, spi_acks, cyc;
  logic [16:0] e;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 7'h00, 8'hE5, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 7'h01, 8'h00, 8'h24};
    vecs[2] = '{1'b0, 1'b1, 7'h10, 8'h5A, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 7'h10, 8'h00, 8'h5A};
    vecs[4] = '{1'b0, 1'b0, 7'h00, 8'h00, 8'hE5};
    vecs[5] = '{1'b1, 1'b1, 7'h7F, 8'hFF, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 7'h7F, 8'h00, 8'hFF};
    vecs[7] = '{1'b1, 1'b0, 7'h01, 8'h00, 8'h24};
    vecs[8] = '{1'b1, 1'b1, 7'h01, 8'hC3, 8'h00};
    vecs[9] = '{1'b0, 1'b0, 7'h01, 8'h00, 8'hC3};

    // Reset state
    tick();
    chk("reset_rm", {rm_en, rm_wr, rm_addr, rm_wdata}, 0);
    chk("reset_ack_rdata", {i2c_ack, spi_ack, i2c_rdata, spi_rdata}, 0);
    chk("reset_owner_ovr_state", {owner_spi, overrun, dbg_state}, 0);
    rst_n = 1'b1;
    tick();

    // Uncontended table: strobe one cycle after the request edge's
    // successor, ack the cycle after that.
    exp_i2c_rd = 8'h00;
    exp_spi_rd = 8'h00;
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].is_spi) post_spi(vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      else                post_i2c(vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      tick();
      i2c_req = 1'b0;
      spi_req = 1'b0;
      chk($sformatf("v%0d_idle_no_en", v), rm_en, 1'b0);
      tick();
      chk($sformatf("v%0d_rm_en", v), rm_en, 1'b1);
      chk($sformatf("v%0d_rm_cmd", v), {rm_wr, rm_addr, rm_wdata},
          {vecs[v].wr, vecs[v].addr, vecs[v].wr ? vecs[v].wdata : rm_wdata});
      chk($sformatf("v%0d_owner", v), owner_spi, vecs[v].is_spi);
      chk($sformatf("v%0d_no_early_ack", v), {i2c_ack, spi_ack}, 2'b00);
      tick();
      if (!vecs[v].wr) begin
        if (vecs[v].is_spi) exp_spi_rd = vecs[v].exp_rdata;
        else                exp_i2c_rd = vecs[v].exp_rdata;
      end
      chk($sformatf("v%0d_rm_en_off", v), rm_en, 1'b0);
      chk($sformatf("v%0d_ack", v), {i2c_ack, spi_ack}, vecs[v].is_spi ? 2'b01 : 2'b10);
      chk($sformatf("v%0d_rdata_at_ack", v), {i2c_rdata, spi_rdata}, {exp_i2c_rd, exp_spi_rd});
      tick();
      chk($sformatf("v%0d_ack_pulse", v), {i2c_ack, spi_ack}, 2'b00);
      chk($sformatf("v%0d_rdata_held", v), {i2c_rdata, spi_rdata}, {exp_i2c_rd, exp_spi_rd});
    end
    chk("table_no_overrun", overrun, 2'b00);

    // Simultaneous writes out of reset: I2C first, SPI strobes 3 cycles later.
    do_reset();
    post_i2c(1'b1, 7'h02, 8'h3A);
    post_spi(1'b1, 7'h02, 8'h92);
    tick();
    i2c_req = 1'b0;
    spi_req = 1'b0;
    tick();
    chk("tie_first_en", rm_en, 1'b1);
    chk("tie_first_i2c", {owner_spi, rm_addr, rm_wdata}, {1'b0, 7'h02, 8'h3A});
    tick();
    chk("tie_i2c_ack", {i2c_ack, spi_ack}, 2'b10);
    tick();
    chk("tie_gap", rm_en, 1'b0);
    tick();
    chk("tie_second_en", rm_en, 1'b1);
    chk("tie_second_spi", {owner_spi, rm_addr, rm_wdata}, {1'b1, 7'h02, 8'h92});
    tick();
    chk("tie_spi_ack", {i2c_ack, spi_ack}, 2'b01);
    tick();
    chk("tie_mem_final", mem[2], 8'h92);

    // Back-to-back saturation: each port re-posts in its own ack cycle.
    do_reset();
    base = act_q.size();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b0, 1'b1, 7'(7'h20 + i), 8'(8'h10 + i)});
      exp_q.push_back({1'b1, 1'b1, 7'(7'h40 + i), 8'(8'hA0 + i)});
    end
    post_i2c(1'b1, 7'h20, 8'h10);
    post_spi(1'b1, 7'h40, 8'hA0);
    i2c_sent = 1; spi_sent = 1; i2c_acks = 0; spi_acks = 0; cyc = 0;
    while ((i2c_acks < 8 || spi_acks < 8) && cyc < 200) begin
      tick();
      cyc++;
      i2c_req = 1'b0;
      spi_req = 1'b0;
      if (i2c_ack) begin
        i2c_acks++;
        if (i2c_sent < 8) begin
          post_i2c(1'b1, 7'(7'h20 + i2c_sent), 8'(8'h10 + i2c_sent));
          i2c_sent++;
        end
      end
      if (spi_ack) begin
        spi_acks++;
        if (spi_sent < 8) begin
          post_spi(1'b1, 7'(7'h40 + spi_sent), 8'(8'hA0 + spi_sent));
          spi_sent++;
        end
      end
    end
    i2c_req = 1'b0;
    spi_req = 1'b0;
    tick();
    chk("b2b_done_in_budget", (cyc < 200) ? 1 : 0, 1);
    chk("b2b_ack_counts", {i2c_acks[7:0], spi_acks[7:0]}, {8'd8, 8'd8});
    chk("b2b_grant_count", act_q.size() - base, 16);
    for (int k = 0; k < 16; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("b2b_grant%0d", k),
          (base + k < act_q.size()) ? act_q[base + k] : 17'h1FFFF, e);
    end
    chk("b2b_no_overrun", overrun, 2'b00);
`ifdef REGMAP_ARB_STATS_EN
    chk("b2b_contention_cnt", contention_cnt, 15);
`endif

    // Overrun: a second SPI request before its ack is dropped.
    do_reset();
    base = act_q.size();
    post_spi(1'b1, 7'h30, 8'h11);
    tick();
    post_spi(1'b1, 7'h30, 8'h22);
    tick();
    spi_req = 1'b0;
    run_cycles(8, n_i2c, n_spi);
    chk("ovr_flags", overrun, 2'b10);
    chk("ovr_ack_counts", {n_i2c[7:0], n_spi[7:0]}, {8'd0, 8'd1});
    chk("ovr_grant_count", act_q.size() - base, 1);
    chk("ovr_grant", (base < act_q.size()) ? act_q[base] : 17'h1FFFF, {1'b1, 1'b1, 7'h30, 8'h11});
    chk("ovr_mem", mem[7'h30], 8'h11);

    // Reset mid-access.
    do_reset();
    post_spi(1'b1, 7'h50, 8'h66);
    tick();
    spi_req = 1'b0;
    tick();
    chk("rstmid_en_before", {rm_en, owner_spi}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_outs_zero",
        {rm_en, owner_spi, rm_wr, rm_addr, rm_wdata, i2c_ack, spi_ack, overrun, dbg_state}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    run_cycles(8, n_i2c, n_spi);
    chk("rstmid_no_ack", {n_i2c[7:0], n_spi[7:0]}, 0);
    chk("rstmid_mem_untouched", mem[7'h50], 8'h00);
    post_i2c(1'b1, 7'h51, 8'h01);
    post_spi(1'b1, 7'h52, 8'h02);
    tick();
    i2c_req = 1'b0;
    spi_req = 1'b0;
    tick();
    chk("rstmid_tie_i2c_first", {rm_en, owner_spi, rm_addr}, {1'b1, 1'b0, 7'h51});
    run_cycles(8, n_i2c, n_spi);
    chk("rstmid_fresh_acks", {n_i2c[7:0], n_spi[7:0]}, {8'd1, 8'd1});
    chk("rstmid_fresh_mem", {mem[7'h51], mem[7'h52]}, {8'h01, 8'h02});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
